// File: rtl/toeplitz_gen.sv
// rtl/toeplitz_gen.sv - Toeplitz matrix generator: loads generator samples, emits N x N matrix row-major
module toeplitz_gen #(
    parameter int DW = 16,
    parameter int N  = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sym,
    input  logic          valid,
    input  logic [DW-1:0] data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_row,
    output logic [AW-1:0] out_col,
    output logic          out_last,
    output logic          busy
);
    localparam int D  = 2 * N - 1;
    localparam int IW = $clog2(D);
    localparam logic [AW:0]   ONE_W  = (AW + 1)'(1);
    localparam logic [AW:0]   NM1_W  = (AW + 1)'(N - 1);
    localparam logic [AW:0]   LEN_S  = (AW + 1)'(N);
    localparam logic [AW:0]   LEN_G  = (AW + 1)'(2 * N - 1);
    localparam logic [AW-1:0] NM1    = AW'(N - 1);
    localparam logic [AW-1:0] ONE    = AW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t        state;
    logic [DW-1:0] buffer [D];
    logic [AW:0]   cnt;
    logic          mode;
    logic [AW-1:0] row, col;

    logic          accept;
    logic          eff_mode;
    logic [AW:0]   len;
    logic [AW:0]   cnt_nxt;
    logic [AW-1:0] nxt_row, nxt_col;
    logic          nxt_last;
    logic [AW:0]   rd_idx;
    logic [DW-1:0] rd_data;

    // Generator index of T[r][c]; general form is rewritten as (r + N-1) - c to stay unsigned.
    function automatic logic [AW:0] elem_idx(input logic [AW:0] r, input logic [AW:0] c,
                                             input logic m);
        if (m)
            return (r >= c) ? (r - c) : (c - r);
        else
            return r + NM1_W - c;
    endfunction

    assign in_ready = (state != EMIT);
    assign busy     = (state != IDLE);
    assign accept   = valid & in_ready;
    assign eff_mode = (state == IDLE) ? sym : mode;
    assign len      = eff_mode ? LEN_S : LEN_G;
    assign cnt_nxt  = cnt + ONE_W;
    assign out_row  = row;
    assign out_col  = col;

    always_comb begin
        nxt_row = row;
        nxt_col = col + ONE;
        if (col == NM1) begin
            nxt_col = '0;
            nxt_row = row + ONE;
        end
        nxt_last = (nxt_row == NM1) && (nxt_col == NM1);
        if (state == EMIT)
            rd_idx = elem_idx({1'b0, nxt_row}, {1'b0, nxt_col}, mode);
        else
            rd_idx = elem_idx('0, '0, eff_mode);
        // Bypass covers the case where T[0][0] comes from the sample being written this cycle.
        rd_data = (accept && (rd_idx == cnt)) ? data : buffer[rd_idx[IW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            row       <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < D; i++)
                buffer[i] <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        buffer[cnt[IW-1:0]] <= data;
                        cnt                 <= cnt_nxt;
                        if (state == IDLE)
                            mode <= sym;
                        if (cnt_nxt == len) begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                            out_data  <= rd_data;
                            row       <= '0;
                            col       <= '0;
                            out_last  <= (N == 1);
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            row       <= '0;
                            col       <= '0;
                            cnt       <= '0;
                        end else begin
                            row      <= nxt_row;
                            col      <= nxt_col;
                            out_data <= rd_data;
                            out_last <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_toeplitz_gen.sv
// tb/tb_toeplitz_gen.sv - randomized self-checking bench for toeplitz_gen against a matrix model
module tb_toeplitz_gen;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, sym, valid, out_ready;
    logic [DW-1:0] data;
    logic          in_ready, out_valid, out_last, busy;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_row, out_col;

    int errors = 0;
    int checks = 0;

    toeplitz_gen #(.DW(DW), .N(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .sym(sym), .valid(valid), .data(data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one matrix worth of samples; optional valid gaps and sym flipping after the first accept.
    task automatic send(input int s[$], input bit m, input bit gaps, input bit toggle);
        int  k  = 0;
        bit  ph = 1'b0;
        while (k < s.size()) begin
            @(negedge clk);
            chk("in_ready_load", in_ready, 1);
            chk("out_valid_load", out_valid, 0);
            chk("busy_load", busy, k > 0);
            if (gaps && ph) begin
                valid = 1'b0;
                data  = DW'($urandom);
            end else begin
                valid = 1'b1;
                data  = DW'(s[k]);
            end
            sym = (k > 0 && toggle) ? ~m : m;
            ph  = ~ph;
            @(posedge clk);
            if (valid) k++;
        end
    endtask

    // Collect elements and compare with T[i][j] computed straight from the sample list.
    task automatic recv(input int s[$], input bit m, input bit rnd_ready, input int stop_after);
        int  ed[$], er[$], ec[$];
        int  k   = 0;
        int  cyc = 0;
        bit  ov;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int d = i - j;
                if (m) ed.push_back(s[d < 0 ? -d : d]);
                else   ed.push_back(s[d + N - 1]);
                er.push_back(i);
                ec.push_back(j);
            end
        while (k < stop_after) begin
            @(negedge clk);
            if (cyc == 0) chk("first_latency", out_valid, 1);
            cyc++;
            if (cyc > 1000) begin
                chk("emit_timeout", k, stop_after);
                break;
            end
            ov = out_valid;
            chk("in_ready_emit", in_ready, 0);
            chk("busy_emit", busy, 1);
            chk("out_valid_emit", out_valid, 1);
            chk("out_data", out_data, ed[k]);
            chk("out_row", out_row, er[k]);
            chk("out_col", out_col, ec[k]);
            chk("out_last", out_last, k == N * N - 1);
            out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
            valid     = (k < N * N - 1) ? 1'($urandom_range(1)) : 1'b0;
            data      = DW'($urandom);
            @(posedge clk);
            if (ov && out_ready) k++;
        end
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_last", out_last, 0);
    endtask

    initial begin
        int s1[$] = '{1, 2, 3, 4, 5, 6, 7};
        int s2[$] = '{10, 20, 30, 40};
        int sr[$];
        bit m;

        rst = 1'b1; sym = 1'b0; valid = 1'b0; data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        send(s1, 1'b0, 1'b0, 1'b0); recv(s1, 1'b0, 1'b0, N * N); idle_chk();
        send(s2, 1'b1, 1'b0, 1'b0); recv(s2, 1'b1, 1'b0, N * N); idle_chk();
        send(s1, 1'b0, 1'b1, 1'b1); recv(s1, 1'b0, 1'b0, N * N); idle_chk();
        send(s1, 1'b0, 1'b0, 1'b0); recv(s1, 1'b0, 1'b1, N * N); idle_chk();

        send(s1, 1'b0, 1'b0, 1'b0); recv(s1, 1'b0, 1'b0, 8);
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        send(s1, 1'b0, 1'b0, 1'b0); recv(s1, 1'b0, 1'b0, N * N); idle_chk();

        send(s1, 1'b0, 1'b0, 1'b0); recv(s1, 1'b0, 1'b0, N * N);
        send(s2, 1'b1, 1'b0, 1'b0); recv(s2, 1'b1, 1'b0, N * N); idle_chk();

        for (int t = 0; t < 8; t++) begin
            m = 1'($urandom_range(1));
            sr.delete();
            for (int i = 0; i < (m ? N : 2 * N - 1); i++)
                sr.push_back(int'(DW'($urandom)));
            send(sr, m, 1'($urandom_range(1)), 1'($urandom_range(1)));
            recv(sr, m, 1'($urandom_range(1)), N * N);
        end
        idle_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
